// File: rtl/aha_dma_irq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aha_dma_irq_ctrl_if
// Brief    : APB control-window bundle shared by the DMA and its IRQ controller
// Revision : 1.0 - initial release
// ============================================================================
interface aha_dma_irq_ctrl_if;
   logic        PCLKEN;
   logic [11:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PCLKEN, PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PCLKEN, PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/aha_dma_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aha_dma_irq_ctrl
// Brief    : Sticky maskable per-channel DMA interrupts plus busy-timeout watchdog
// Revision : 1.0 - initial release
// ============================================================================
module aha_dma_irq_ctrl #(
   parameter int          NUM_CH   = 4,
   parameter int          TMR_W    = 16,
   parameter logic [31:0] ID_VALUE = 32'h4448_0002
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   aha_dma_irq_ctrl_if.slave   apb,
   input  logic [NUM_CH-1:0]   CH_DONE,
   input  logic [NUM_CH-1:0]   CH_ERR,
   input  logic [NUM_CH-1:0]   CH_BUSY,
   output logic [NUM_CH-1:0]   IRQ,
   output logic                IRQ_ABORT
);

   localparam logic [9:0]       c_word_done  = 10'd0;
   localparam logic [9:0]       c_word_err   = 10'd1;
   localparam logic [9:0]       c_word_en    = 10'd2;
   localparam logic [9:0]       c_word_tmo   = 10'd3;
   localparam logic [9:0]       c_word_abort = 10'd4;
   localparam logic [9:0]       c_word_busy  = 10'd5;
   localparam logic [9:0]       c_word_id    = 10'd6;
   localparam logic [TMR_W-1:0] c_tmr_one    = TMR_W'(1);

   logic [NUM_CH-1:0] r_done_stat;
   logic [NUM_CH-1:0] r_err_stat;
   logic [NUM_CH-1:0] r_irq_en;
   logic [TMR_W-1:0]  r_timeout;
   logic              r_abort_flag;
   logic [3:0]        r_abort_idx;

   logic              w_acc;
   logic              w_wr;
   logic [9:0]        w_word;
   logic              w_mapped;
   logic              w_wr_tmo;
   logic              w_tmr_off;
   logic              w_abort_clr;
   logic [NUM_CH-1:0] w_done_clr;
   logic [NUM_CH-1:0] w_err_clr;
   logic [NUM_CH-1:0] w_expired;
   logic [3:0]        w_first_idx;
   logic [31:0]       w_rdata;
   logic              w_unused;

   assign w_acc       = apb.PSEL & apb.PENABLE & apb.PCLKEN;
   assign w_wr        = w_acc & apb.PWRITE;
   assign w_word      = apb.PADDR[11:2];
   assign w_mapped    = (w_word <= c_word_id);
   assign w_wr_tmo    = w_wr & (w_word == c_word_tmo);
   assign w_tmr_off   = (r_timeout == '0);
   assign w_abort_clr = w_wr & (w_word == c_word_abort) & apb.PWDATA[0];
   assign w_done_clr  = {NUM_CH{w_wr & (w_word == c_word_done)}} & apb.PWDATA[NUM_CH-1:0];
   assign w_err_clr   = {NUM_CH{w_wr & (w_word == c_word_err)}}  & apb.PWDATA[NUM_CH-1:0];
   assign w_unused    = ^{apb.PADDR[1:0], apb.PWDATA};

   // Per-channel busy counters; a TIMEOUT write restarts every channel from zero.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [TMR_W-1:0] r_cnt;

      always_ff @(posedge ACLK or negedge ARESETn) begin
         if (!ARESETn) begin
            r_cnt <= '0;
         end else if (!CH_BUSY[gi] || w_tmr_off || w_wr_tmo) begin
            r_cnt <= '0;
         end else if (r_cnt < r_timeout) begin
            r_cnt <= r_cnt + c_tmr_one;
         end
      end

      assign w_expired[gi] = CH_BUSY[gi] & ~w_tmr_off & (r_cnt == r_timeout);
   end

   // Descending scan so the lowest expiring channel wins.
   always_comb begin
      w_first_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_expired[i]) w_first_idx = 4'(i);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_done_stat  <= '0;
         r_err_stat   <= '0;
         r_irq_en     <= '0;
         r_timeout    <= '0;
         r_abort_flag <= 1'b0;
         r_abort_idx  <= '0;
      end else begin
         r_done_stat <= (r_done_stat & ~w_done_clr) | CH_DONE;
         r_err_stat  <= (r_err_stat  & ~w_err_clr)  | CH_ERR;
         if (w_wr && (w_word == c_word_en)) r_irq_en <= apb.PWDATA[NUM_CH-1:0];
         if (w_wr_tmo) r_timeout <= apb.PWDATA[TMR_W-1:0];
         if (!r_abort_flag && (|w_expired)) begin
            r_abort_flag <= 1'b1;
            r_abort_idx  <= w_first_idx;
         end else if (w_abort_clr) begin
            r_abort_flag <= 1'b0;
            r_abort_idx  <= '0;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_word)
         c_word_done:  w_rdata[NUM_CH-1:0] = r_done_stat;
         c_word_err:   w_rdata[NUM_CH-1:0] = r_err_stat;
         c_word_en:    w_rdata[NUM_CH-1:0] = r_irq_en;
         c_word_tmo:   w_rdata[TMR_W-1:0]  = r_timeout;
         c_word_abort: begin
            w_rdata[0]    = r_abort_flag;
            w_rdata[11:8] = r_abort_idx;
         end
         c_word_busy:  w_rdata[NUM_CH-1:0] = CH_BUSY;
         c_word_id:    w_rdata = ID_VALUE;
         default:      w_rdata = '0;
      endcase
   end

   assign apb.PRDATA  = (apb.PSEL & apb.PENABLE) ? w_rdata : 32'h0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = w_acc & ~w_mapped;

   assign IRQ       = r_irq_en & (r_done_stat | r_err_stat);
   assign IRQ_ABORT = r_abort_flag;

endmodule
`default_nettype wire

// File: tb/tb_aha_dma_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aha_dma_irq_ctrl
// Brief    : Directed plus random bench for aha_dma_irq_ctrl against a reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_aha_dma_irq_ctrl;
   localparam int          NUM_CH   = 4;
   localparam int          TMR_W    = 16;
   localparam logic [31:0] ID_VALUE = 32'h4448_0002;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] ch_done = '0;
   logic [NUM_CH-1:0] ch_err  = '0;
   logic [NUM_CH-1:0] ch_busy = '0;
   logic [NUM_CH-1:0] irq;
   logic              irq_abort;
   logic              chk_on = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   aha_dma_irq_ctrl_if apb_if();

   aha_dma_irq_ctrl #(
      .NUM_CH   (NUM_CH),
      .TMR_W    (TMR_W),
      .ID_VALUE (ID_VALUE)
   ) u_dut (
      .ACLK      (clk),
      .ARESETn   (rst_n),
      .apb       (apb_if.slave),
      .CH_DONE   (ch_done),
      .CH_ERR    (ch_err),
      .CH_BUSY   (ch_busy),
      .IRQ       (irq),
      .IRQ_ABORT (irq_abort)
   );

   always #5 clk = ~clk;

   // Reference state: status sets, masks, and per-channel busy age in cycles.
   logic [NUM_CH-1:0] m_done = '0;
   logic [NUM_CH-1:0] m_err  = '0;
   logic [NUM_CH-1:0] m_en   = '0;
   int                m_tmo  = 0;
   bit                m_abort = 1'b0;
   int                m_idx  = 0;
   int                m_age [NUM_CH] = '{default: 0};
   bit                m_wr;
   int                m_word;
   int                m_first;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_done = '0; m_err = '0; m_en = '0; m_tmo = 0; m_abort = 0; m_idx = 0;
         for (int i = 0; i < NUM_CH; i++) m_age[i] = 0;
      end else begin
         m_wr   = apb_if.PSEL && apb_if.PENABLE && apb_if.PCLKEN && apb_if.PWRITE;
         m_word = int'(apb_if.PADDR[11:2]);
         m_first = -1;
         if (m_tmo != 0)
            for (int i = NUM_CH - 1; i >= 0; i--)
               if (ch_busy[i] && m_age[i] >= m_tmo) m_first = i;
         for (int i = 0; i < NUM_CH; i++) begin
            if (m_wr && m_word == 0 && apb_if.PWDATA[i]) m_done[i] = 1'b0;
            if (ch_done[i]) m_done[i] = 1'b1;
            if (m_wr && m_word == 1 && apb_if.PWDATA[i]) m_err[i] = 1'b0;
            if (ch_err[i]) m_err[i] = 1'b1;
            if (!ch_busy[i] || m_tmo == 0 || (m_wr && m_word == 3)) m_age[i] = 0;
            else m_age[i] = m_age[i] + 1;
         end
         if (m_wr && m_word == 2) m_en = apb_if.PWDATA[NUM_CH-1:0];
         if (!m_abort && m_first >= 0) begin
            m_abort = 1'b1; m_idx = m_first;
         end else if (m_wr && m_word == 4 && apb_if.PWDATA[0]) begin
            m_abort = 1'b0; m_idx = 0;
         end
         if (m_wr && m_word == 3) m_tmo = int'(apb_if.PWDATA[TMR_W-1:0]);
      end
   end

   function automatic logic [31:0] model_read(input logic [11:0] addr);
      logic [31:0] v;
      v = 32'h0;
      case (int'(addr[11:2]))
         0: v = 32'(m_done);
         1: v = 32'(m_err);
         2: v = 32'(m_en);
         3: v = 32'(m_tmo);
         4: v = (m_abort ? 32'h1 : 32'h0) | (32'(m_idx) << 8);
         5: v = 32'(ch_busy);
         6: v = ID_VALUE;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("irq_model", 32'(irq), 32'(m_en & (m_done | m_err)));
         check("abort_model", 32'(irq_abort), 32'(m_abort));
         check("pready", 32'(apb_if.PREADY), 32'h1);
         if (apb_if.PSEL && apb_if.PENABLE) begin
            if (!apb_if.PWRITE) check("prdata_model", apb_if.PRDATA, model_read(apb_if.PADDR));
            check("pslverr_model", 32'(apb_if.PSLVERR),
                  32'(apb_if.PCLKEN && (apb_if.PADDR[11:2] > 10'd6)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apb_idle();
      apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0; apb_if.PCLKEN = 1'b1;
   endtask

   task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, input logic en,
                            input logic [NUM_CH-1:0] err_pulse, output logic err);
      apb_if.PADDR = addr; apb_if.PWDATA = data; apb_if.PWRITE = 1'b1;
      apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PCLKEN = en;
      tick();
      apb_if.PENABLE = 1'b1;
      ch_err = err_pulse;
      @(negedge clk);
      err = apb_if.PSLVERR;
      tick();
      ch_err = '0;
      apb_idle();
   endtask

   task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
      apb_if.PADDR = addr; apb_if.PWRITE = 1'b0;
      apb_if.PSEL = 1'b1; apb_if.PENABLE = 1'b0; apb_if.PCLKEN = 1'b1;
      tick();
      apb_if.PENABLE = 1'b1;
      @(negedge clk);
      data = apb_if.PRDATA;
      err  = apb_if.PSLVERR;
      tick();
      apb_idle();
   endtask

   task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_read(addr, d, e);
      check(tag, d, exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic        e;
      logic [31:0] d;
      int          rise;

      apb_idle();
      apb_if.PADDR = '0; apb_if.PWDATA = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_abort", 32'(irq_abort), 32'h0);
      check("rst_pready", 32'(apb_if.PREADY), 32'h1);
      check("rst_pslverr", 32'(apb_if.PSLVERR), 32'h0);
      check("rst_prdata", apb_if.PRDATA, 32'h0);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      tick();

      read_check("rst_done", 12'h000, 32'h0);
      read_check("rst_err", 12'h004, 32'h0);
      read_check("rst_en", 12'h008, 32'h0);
      read_check("rst_tmo", 12'h00C, 32'h0);
      read_check("rst_abortstat", 12'h010, 32'h0);
      read_check("id", 12'h018, 32'h4448_0002);

      // Done pulses, masking and W1C
      apb_write(12'h008, 32'h5, 1'b1, '0, e);
      ch_done = 4'h3;
      tick();
      ch_done = 4'h0;
      @(negedge clk); check("irq_after_done", 32'(irq), 32'h1);
      tick();
      read_check("done_stat", 12'h000, 32'h3);
      apb_write(12'h000, 32'h1, 1'b1, '0, e);
      @(negedge clk); check("irq_after_w1c", 32'(irq), 32'h0);
      tick();
      read_check("done_after_w1c", 12'h000, 32'h2);

      // Set beats clear when both hit the same bit in one cycle
      apb_write(12'h004, 32'h4, 1'b1, 4'h4, e);
      @(negedge clk); check("irq_set_wins", 32'(irq), 32'h4);
      tick();
      read_check("err_set_wins", 12'h004, 32'h4);

      // Watchdog: lowest of two simultaneous expiries is captured
      apb_write(12'h00C, 32'd10, 1'b1, '0, e);
      ch_busy = 4'b1010;
      rise = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (irq_abort) begin
            rise = c;
            break;
         end
         tick();
      end
      tick();
      check("abort_rise_cycle", 32'(rise), 32'd11);
      read_check("abort_stat_ch1", 12'h010, 32'h101);
      ch_busy = 4'b0000;
      tick();
      apb_write(12'h010, 32'h1, 1'b1, '0, e);
      @(negedge clk); check("abort_cleared", 32'(irq_abort), 32'h0);
      tick();
      read_check("abort_stat_clr", 12'h010, 32'h0);

      // A saturated busy channel re-raises the abort right after W1C
      ch_busy = 4'b0100;
      repeat (12) tick();
      @(negedge clk); check("abort_ch2_set", 32'(irq_abort), 32'h1);
      tick();
      apb_write(12'h010, 32'h1, 1'b1, '0, e);
      @(negedge clk); check("abort_w1c_low", 32'(irq_abort), 32'h0);
      tick();
      @(negedge clk); check("abort_reassert", 32'(irq_abort), 32'h1);
      tick();
      read_check("abort_stat_ch2", 12'h010, 32'h201);
      ch_busy = 4'b0000;
      tick();
      apb_write(12'h010, 32'h1, 1'b1, '0, e);

      // Gated clock enable and unmapped addresses
      apb_write(12'h008, 32'hF, 1'b0, '0, e);
      read_check("pclken_gated", 12'h008, 32'h5);
      apb_write(12'h040, 32'hFFFF_FFFF, 1'b1, '0, e);
      check("unmapped_wr_err", 32'(e), 32'h1);
      apb_read(12'h040, d, e);
      check("unmapped_rd_data", d, 32'h0);
      check("unmapped_rd_err", 32'(e), 32'h1);

      // Asynchronous reset in the middle of activity
      ch_done = 4'hF;
      tick();
      ch_done = 4'h0;
      apb_write(12'h008, 32'hF, 1'b1, '0, e);
      ch_busy = 4'hF;
      repeat (13) tick();
      @(negedge clk);
      check("pre_rst_irq", 32'(irq), 32'hF);
      check("pre_rst_abort", 32'(irq_abort), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_irq", 32'(irq), 32'h0);
      check("async_rst_abort", 32'(irq_abort), 32'h0);
      ch_busy = 4'h0;
      tick();
      rst_n = 1'b1;
      tick();
      read_check("post_rst_done", 12'h000, 32'h0);
      read_check("post_rst_en", 12'h008, 32'h0);
      read_check("post_rst_tmo", 12'h00C, 32'h0);
      read_check("post_rst_abort", 12'h010, 32'h0);

      // Random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         ch_done = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         ch_err  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(0, 11) == 0) ch_busy[i] = ~ch_busy[i];
         apb_if.PSEL    = 1'($urandom_range(0, 1));
         apb_if.PENABLE = apb_if.PSEL & ($urandom_range(0, 3) != 0);
         apb_if.PCLKEN  = ($urandom_range(0, 7) != 0);
         apb_if.PWRITE  = 1'($urandom_range(0, 1));
         apb_if.PADDR   = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                          : {7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         apb_if.PWDATA  = (apb_if.PADDR[11:2] == 10'd3) ? 32'($urandom_range(0, 12)) : $urandom;
         tick();
      end
      apb_idle();
      ch_done = '0; ch_err = '0; ch_busy = '0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
